// File: rtl/mmio_uart_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : mmio_uart_tx_if
// Description : CPU data-bus slice seen by the memory-mapped UART transmitter.
//   addr    : byte address from the CPU
//   we      : write enable
//   datain  : write data from the CPU
//   dataout : registered read data from the peripheral
//   hit     : combinational address-window decode from the peripheral
// Revision    : 1.0 - initial release
// ============================================================================
interface mmio_uart_tx_if;
  logic [31:0] addr;
  logic        we;
  logic [31:0] datain;
  logic [31:0] dataout;
  logic        hit;

  modport master (
    output addr,
    output we,
    output datain,
    input  dataout,
    input  hit
  );

  modport slave (
    input  addr,
    input  we,
    input  datain,
    output dataout,
    output hit
  );
endinterface
`default_nettype wire

// File: rtl/mmio_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : mmio_uart_tx
// Description : Memory-mapped 8N1 UART transmitter with a TX FIFO.
//   Register window (word offsets from BASE_ADDR):
//     0x0 TXDATA (W: push datain[7:0], R: 0)
//     0x4 STATUS (R: busy/full/empty/overflow/count, W: bit3 clears overflow)
//     0x8 CLKDIV (R/W bits[15:0], clk cycles per bit, minimum 2)
//   Ports:
//     clk  : system clock, rising edge
//     rst  : asynchronous active-low reset
//     bus  : CPU data bus slave (addr, we, datain, dataout, hit)
//     txd  : serial output, idle high, registered
// Revision    : 1.0 - initial release
// ============================================================================
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR   = 32'hFFFF_0100,
  parameter int          FIFO_DEPTH  = 16,
  parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
  input  logic          clk,
  input  logic          rst,
  mmio_uart_tx_if.slave bus,
  output logic          txd
);

  localparam int              AW     = $clog2(FIFO_DEPTH);
  localparam int              CW     = AW + 1;
  localparam logic [CW-1:0]   C_FULL = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  // FIFO storage and bookkeeping
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          r_ovf;
  logic [15:0]   r_clkdiv;
  logic [31:0]   r_dataout;

  // Serializer
  state_t        r_state;
  logic [7:0]    r_shift;
  logic [2:0]    r_idx;
  logic [15:0]   r_bcnt;
  logic          r_txd;

  logic [1:0]    w_sel;
  logic          w_hit;
  logic          w_wr;
  logic          w_push_req;
  logic          w_empty;
  logic          w_full;
  logic          w_bit_end;
  logic          w_pop;
  logic          w_push;
  logic          w_ovf_set;
  logic          w_busy;
  logic [15:0]   w_reload;
  logic [31:0]   w_cnt_ext;
  logic [31:0]   w_status;
  logic [31:0]   w_rdata;

  assign w_sel      = bus.addr[3:2];
  assign w_hit      = (bus.addr[31:4] == BASE_ADDR[31:4]) && (w_sel != 2'b11);
  assign bus.hit    = w_hit;
  assign w_wr       = bus.we & w_hit;
  assign w_push_req = w_wr && (w_sel == 2'b00);

  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == C_FULL);
  assign w_bit_end  = (r_bcnt == 16'd0);

  // The serializer takes a byte when idle, or back-to-back at the end of a
  // stop bit. Gating on non-empty means a push into an empty FIFO is never
  // paired with a pop in the same cycle.
  assign w_pop      = !w_empty &&
                      ((r_state == ST_IDLE) || ((r_state == ST_STOP) && w_bit_end));
  // A pop frees a slot in the same cycle, so a full FIFO still accepts.
  assign w_push     = w_push_req && (!w_full || w_pop);
  assign w_ovf_set  = w_push_req && w_full && !w_pop;

  assign w_busy     = !w_empty || (r_state != ST_IDLE);
  // Every bit start reloads from the live CLKDIV, so a mid-frame divisor
  // change only affects subsequent bits.
  assign w_reload   = r_clkdiv - 16'd1;

  // Count reported in 8 bits; with FIFO_DEPTH=256 a full FIFO shows 0 here
  // and firmware must use the full flag.
  assign w_cnt_ext  = 32'(r_count);
  assign w_status   = {16'h0000, w_cnt_ext[7:0], 4'h0, r_ovf, w_empty, w_full, w_busy};

  always_comb begin
    w_rdata = 32'h0;
    if (w_hit) begin
      case (w_sel)
        2'b01:   w_rdata = w_status;
        2'b10:   w_rdata = {16'h0000, r_clkdiv};
        default: w_rdata = 32'h0;
      endcase
    end
  end

  assign bus.dataout = r_dataout;
  assign txd         = r_txd;

  // FIFO storage needs no reset; only the pointers and count define contents.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= bus.datain[7:0];
    end
  end

  // Bus-side registers and FIFO pointers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_ovf     <= 1'b0;
      r_clkdiv  <= DEFAULT_DIV;
      r_dataout <= 32'h0;
    end else begin
      r_dataout <= w_rdata;
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_ovf_set) begin
        r_ovf <= 1'b1;
      end else if (w_wr && (w_sel == 2'b01) && bus.datain[3]) begin
        r_ovf <= 1'b0;
      end
      if (w_wr && (w_sel == 2'b10)) begin
        r_clkdiv <= (bus.datain[15:0] < 16'd2) ? 16'd2 : bus.datain[15:0];
      end
    end
  end

  // 8N1 serializer; txd is registered alongside every state transition.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_shift <= 8'h00;
      r_idx   <= 3'd0;
      r_bcnt  <= 16'd0;
      r_txd   <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_txd <= 1'b1;
          if (w_pop) begin
            r_shift <= r_mem[r_rptr];
            r_bcnt  <= w_reload;
            r_state <= ST_START;
            r_txd   <= 1'b0;
          end
        end
        ST_START: begin
          if (w_bit_end) begin
            r_idx   <= 3'd0;
            r_bcnt  <= w_reload;
            r_state <= ST_DATA;
            r_txd   <= r_shift[0];
          end else begin
            r_bcnt <= r_bcnt - 16'd1;
          end
        end
        ST_DATA: begin
          if (w_bit_end) begin
            r_bcnt <= w_reload;
            if (r_idx == 3'd7) begin
              r_state <= ST_STOP;
              r_txd   <= 1'b1;
            end else begin
              r_idx   <= r_idx + 3'd1;
              r_shift <= r_shift >> 1;
              r_txd   <= r_shift[1];
            end
          end else begin
            r_bcnt <= r_bcnt - 16'd1;
          end
        end
        ST_STOP: begin
          if (w_bit_end) begin
            if (w_pop) begin
              r_shift <= r_mem[r_rptr];
              r_bcnt  <= w_reload;
              r_state <= ST_START;
              r_txd   <= 1'b0;
            end else begin
              r_state <= ST_IDLE;
              r_txd   <= 1'b1;
            end
          end else begin
            r_bcnt <= r_bcnt - 16'd1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_txd   <= 1'b1;
        end
      endcase
    end
  end

  // Address byte lanes and upper data bits carry no meaning here.
  logic w_unused;
  assign w_unused = &{1'b0, bus.addr[1:0], bus.datain[31:16], w_cnt_ext[31:8]};

endmodule
`default_nettype wire

// File: tb/tb_mmio_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_mmio_uart_tx
// Description : Directed self-checking bench for mmio_uart_tx. Drives the
//               CPU bus through the interface on falling edges and samples
//               outputs on falling edges, away from the active edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mmio_uart_tx;

  localparam logic [31:0] BASE = 32'hFFFF_0100;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic txd;

  int tests = 0;
  int fails = 0;

  logic [7:0] frame_bytes [4];

  mmio_uart_tx_if bus ();

  mmio_uart_tx #(
    .BASE_ADDR  (BASE),
    .FIFO_DEPTH (16),
    .DEFAULT_DIV(16'd434)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .txd(txd)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; the write lands on the next rising edge and
  // the task returns at the following falling edge.
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus.addr   = a;
    bus.we     = 1'b1;
    bus.datain = d;
    @(negedge clk);
    bus.we     = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    bus.addr = a;
    bus.we   = 1'b0;
    @(negedge clk);
    check(tag, bus.dataout, exp);
  endtask

  // Expected txd i cycles after the write edge of the first byte of a
  // back-to-back stream of frames from frame_bytes.
  function automatic logic exp_txd(input int i, input int div);
    int f;
    int r;
    int b;
    logic [7:0] byt;
    if (i == 0) return 1'b1;
    f = (i - 1) / (10 * div);
    r = (i - 1) % (10 * div);
    b = r / div;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    byt = frame_bytes[f];
    return byt[b-1];
  endfunction

  task automatic check_stream(input int first, input int last, input int div);
    for (int i = first; i <= last; i++) begin
      if (i > first) @(negedge clk);
      check($sformatf("txd_i%0d", i), {31'b0, txd}, {31'b0, exp_txd(i, div)});
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lows;
    bus.addr   = 32'h0;
    bus.we     = 1'b0;
    bus.datain = 32'h0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_txd", {31'b0, txd}, 32'h1);
    check("rst_dataout", bus.dataout, 32'h0);
    rst = 1'b1;
    rd("rst_status", BASE + 32'h4, 32'h0000_0004);
    rd("rst_clkdiv", BASE + 32'h8, 32'd434);
    check("rst_txd_idle", {31'b0, txd}, 32'h1);

    // Single frame 0x55 at div 4
    wr(BASE + 32'h8, 32'd4);
    frame_bytes[0] = 8'h55;
    wr(BASE, 32'h55);
    check_stream(0, 40, 4);
    repeat (3) @(negedge clk);
    rd("f1_status_idle", BASE + 32'h4, 32'h0000_0004);

    // Three back-to-back frames at div 2
    wr(BASE + 32'h8, 32'd2);
    frame_bytes[0] = 8'hA1;
    frame_bytes[1] = 8'h00;
    frame_bytes[2] = 8'hFF;
    wr(BASE, 32'hA1);
    wr(BASE, 32'h00);
    wr(BASE, 32'hFF);
    check_stream(2, 60, 2);
    repeat (3) @(negedge clk);
    rd("f3_status_idle", BASE + 32'h4, 32'h0000_0004);

    // Fill to full, then overflow, then clear overflow
    wr(BASE + 32'h8, 32'd1000);
    for (int k = 0; k < 17; k++) wr(BASE, 32'h10 + k);
    rd("full_status", BASE + 32'h4, 32'h0000_1003);
    wr(BASE, 32'hEE);
    rd("ovf_status", BASE + 32'h4, 32'h0000_100B);
    wr(BASE + 32'h4, 32'h8);
    rd("ovf_clear", BASE + 32'h4, 32'h0000_1003);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    // Divisor clamp and mid-start divisor change
    wr(BASE + 32'h8, 32'd0);
    rd("clkdiv_clamp", BASE + 32'h8, 32'd2);
    wr(BASE + 32'h8, 32'd4);
    wr(BASE, 32'h01);
    check("div_i0", {31'b0, txd}, 32'h1);
    @(negedge clk);
    check("div_i1", {31'b0, txd}, 32'h0);
    wr(BASE + 32'h8, 32'd8);
    check("div_i2", {31'b0, txd}, 32'h0);
    for (int i = 3; i <= 13; i++) begin
      @(negedge clk);
      check($sformatf("div_i%0d", i), {31'b0, txd},
            (i <= 4) ? 32'h0 : (i <= 12) ? 32'h1 : 32'h0);
    end
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    // Asynchronous reset mid-DATA with three bytes queued
    wr(BASE + 32'h8, 32'd4);
    wr(BASE, 32'h00);
    wr(BASE, 32'h11);
    wr(BASE, 32'h22);
    wr(BASE, 32'h33);
    rd("mid_clkdiv", BASE + 32'h8, 32'd4);
    repeat (3) @(negedge clk);
    check("mid_txd_data0", {31'b0, txd}, 32'h0);
    #2;
    rst = 1'b0;
    #1;
    check("mid_rst_txd", {31'b0, txd}, 32'h1);
    check("mid_rst_dataout", bus.dataout, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    rd("post_rst_status", BASE + 32'h4, 32'h0000_0004);
    lows = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (txd !== 1'b1) lows++;
    end
    check("post_rst_quiet", lows, 32'd0);
    rd("post_rst_clkdiv", BASE + 32'h8, 32'd434);

    // Out-of-window and reserved addresses
    bus.addr = BASE + 32'hC;
    #1;
    check("hit_0xC", {31'b0, bus.hit}, 32'h0);
    bus.addr = BASE + 32'h8;
    #1;
    check("hit_0x8", {31'b0, bus.hit}, 32'h1);
    bus.addr = BASE + 32'h10;
    #1;
    check("hit_0x10", {31'b0, bus.hit}, 32'h0);
    @(negedge clk);
    wr(BASE + 32'hC, 32'hFFFF_FFFF);
    wr(BASE + 32'h10, 32'h05);
    wr(BASE + 32'h18, 32'd3);
    rd("miss_clkdiv", BASE + 32'h8, 32'd434);
    rd("miss_rd_0xC", BASE + 32'hC, 32'h0);
    rd("miss_rd_0x10", BASE + 32'h10, 32'h0);
    rd("miss_status", BASE + 32'h4, 32'h0000_0004);
    check("miss_txd", {31'b0, txd}, 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
